vram_touch_painter: RTL and testbench

- Write-side owner of the VRAM write port. It sits between the touch controller outputs and the block_ram write port; the display controller is the reader on the other port.
- Clears VRAM to a base colour after reset or on request.
- On each new valid touch, paints a square brush of pixels centred on the touch point into VRAM, clipped at the display edges.
- Issues one write per cycle on registered outputs.

---
 rtl/vram_pkg.sv | 22 ++
 rtl/vram_touch_painter_brush_scanner.sv | 67 ++++++
 rtl/vram_touch_painter.sv | 183 ++++++++++++++++++
 tb/tb_vram_touch_painter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM write path.
package vram_pkg;

   typedef logic [15:0] color_t;

   // RGB565 colour constants
   localparam color_t WHITE = 16'hFFFF;
   localparam color_t BLACK = 16'h0000;
   localparam color_t RED   = 16'hF800;
   localparam color_t GREEN = 16'h07E0;
   localparam color_t BLUE  = 16'h001F;

   localparam int DISPLAY_WIDTH_DEF  = 240;
   localparam int DISPLAY_HEIGHT_DEF = 320;
   localparam int VRAM_L_DEF         = DISPLAY_WIDTH_DEF * DISPLAY_HEIGHT_DEF;

   // Width of the signed brush offsets; covers brushes up to 255 pixels.
   localparam int OFF_W = 8;

   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_PAINT} painter_state_t;

endpackage

// File: rtl/vram_touch_painter_brush_scanner.sv
// Steps signed (dx, dy) offsets over -R..R in raster order, dx innermost.
module brush_scanner
   import vram_pkg::*;
#(
   parameter int BRUSH = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    start,
   input  logic                    ena,
   output logic signed [OFF_W-1:0] dx,
   output logic signed [OFF_W-1:0] dy,
   output logic                    valid,
   output logic                    last
);

   localparam logic signed [OFF_W-1:0] R     = OFF_W'((BRUSH - 1) / 2);
   localparam logic signed [OFF_W-1:0] NEG_R = -R;

   logic signed [OFF_W-1:0] dx_q, dx_d, dy_q, dy_d;
   logic                    valid_q, valid_d;

   assign dx    = dx_q;
   assign dy    = dy_q;
   assign valid = valid_q;
   assign last  = valid_q && (dx_q == R) && (dy_q == R);

   // Next offset: clear wins, then start, then advance on enabled cycles.
   always_comb begin
      dx_d    = dx_q;
      dy_d    = dy_q;
      valid_d = valid_q;
      if (clr) begin
         valid_d = 1'b0;
         dx_d    = NEG_R;
         dy_d    = NEG_R;
      end else if (start) begin
         valid_d = 1'b1;
         dx_d    = NEG_R;
         dy_d    = NEG_R;
      end else if (ena && valid_q) begin
         if (last) begin
            valid_d = 1'b0;
         end else if (dx_q == R) begin
            dx_d = NEG_R;
            dy_d = dy_q + OFF_W'(1);
         end else begin
            dx_d = dx_q + OFF_W'(1);
         end
      end
   end

   // Offset registers
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         dx_q    <= NEG_R;
         dy_q    <= NEG_R;
      end else begin
         valid_q <= valid_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
      end
   end

endmodule

// File: rtl/vram_touch_painter.sv
// VRAM write-port owner: clears VRAM, then paints clipped square brushes at touch points.
module vram_touch_painter
   import vram_pkg::*;
#(
   parameter int     DISPLAY_WIDTH  = DISPLAY_WIDTH_DEF,
   parameter int     DISPLAY_HEIGHT = DISPLAY_HEIGHT_DEF,
   parameter int     VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
   parameter int     ADDR_W         = $clog2(VRAM_L),
   parameter int     BRUSH          = 3,
   parameter color_t CLEAR_COLOR    = 16'hFFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              clear_req,
   input  logic              touch_valid,
   input  logic [8:0]        touch_x,
   input  logic [8:0]        touch_y,
   input  logic [15:0]       color,
   output logic              vram_wr_ena,
   output logic [ADDR_W-1:0] vram_wr_addr,
   output logic [15:0]       vram_wr_data,
   output logic              clearing,
   output logic              busy
);

   localparam int                  CW         = 12;
   localparam logic signed [CW-1:0] W_S        = CW'(DISPLAY_WIDTH);
   localparam logic signed [CW-1:0] H_S        = CW'(DISPLAY_HEIGHT);
   localparam logic [9:0]          W_U        = 10'(DISPLAY_WIDTH);
   localparam logic [9:0]          H_U        = 10'(DISPLAY_HEIGHT);
   localparam logic [ADDR_W-1:0]   LAST_ADDR  = ADDR_W'(VRAM_L - 1);
   localparam logic [ADDR_W-1:0]   ROW_STRIDE = ADDR_W'(DISPLAY_WIDTH);

   painter_state_t    state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [8:0]        x_q, x_d, y_q, y_d;
   color_t            color_q, color_d;
   logic              stroke_valid_q, stroke_valid_d;
   logic              wr_ena_q, wr_ena_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   color_t            data_q, data_d;
   logic              clearing_q, clearing_d;
   logic              busy_q, busy_d;

   logic                    scan_start, scan_ena;
   logic signed [OFF_W-1:0] scan_dx, scan_dy;
   logic                    scan_valid, scan_last;
   logic signed [CW-1:0]    dx_ext, dy_ext, px, py;
   logic                    in_bounds, touch_in_range, touch_repeat;
   logic [ADDR_W-1:0]       pix_addr;

   assign scan_ena = ena && (state_q == S_PAINT);

   brush_scanner #(
      .BRUSH (BRUSH)
   ) u_scanner (
      .clk   (clk),
      .rst   (rst),
      .clr   (clear_req),
      .start (scan_start),
      .ena   (scan_ena),
      .dx    (scan_dx),
      .dy    (scan_dy),
      .valid (scan_valid),
      .last  (scan_last)
   );

   // Brush pixel position, clip test and address; only the row stride multiply is constant.
   always_comb begin
      dx_ext    = {{(CW - OFF_W){scan_dx[OFF_W-1]}}, scan_dx};
      dy_ext    = {{(CW - OFF_W){scan_dy[OFF_W-1]}}, scan_dy};
      px        = $signed({{(CW - 9){1'b0}}, x_q}) + dx_ext;
      py        = $signed({{(CW - 9){1'b0}}, y_q}) + dy_ext;
      in_bounds = !px[CW-1] && (px < W_S) && !py[CW-1] && (py < H_S);
      pix_addr  = ADDR_W'(py[CW-2:0]) * ROW_STRIDE + ADDR_W'(px[CW-2:0]);
      touch_in_range = ({1'b0, touch_x} < W_U) && ({1'b0, touch_y} < H_U);
      touch_repeat   = stroke_valid_q && (touch_x == x_q) && (touch_y == y_q) &&
                       (color == color_q);
   end

   // Next state and next registered outputs; clear_req overrides everything.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      x_d            = x_q;
      y_d            = y_q;
      color_d        = color_q;
      stroke_valid_d = stroke_valid_q;
      wr_ena_d       = 1'b0;
      addr_d         = addr_q;
      data_d         = data_q;
      clearing_d     = clearing_q;
      busy_d         = busy_q;
      scan_start     = 1'b0;
      if (clear_req) begin
         state_d        = S_CLEAR;
         cnt_d          = '0;
         stroke_valid_d = 1'b0;
         clearing_d     = 1'b1;
         busy_d         = 1'b1;
      end else if (ena) begin
         unique case (state_q)
            S_CLEAR: begin
               wr_ena_d   = 1'b1;
               addr_d     = cnt_q;
               data_d     = CLEAR_COLOR;
               clearing_d = 1'b1;
               busy_d     = 1'b1;
               if (cnt_q == LAST_ADDR) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + ADDR_W'(1);
               end
            end
            S_IDLE: begin
               clearing_d = 1'b0;
               busy_d     = 1'b0;
               if (touch_valid && touch_in_range && !touch_repeat) begin
                  x_d            = touch_x;
                  y_d            = touch_y;
                  color_d        = color;
                  stroke_valid_d = 1'b1;
                  scan_start     = 1'b1;
                  state_d        = S_PAINT;
               end
            end
            S_PAINT: begin
               clearing_d = 1'b0;
               busy_d     = 1'b1;
               if (scan_valid) begin
                  wr_ena_d = in_bounds;
                  if (in_bounds) begin
                     addr_d = pix_addr;
                     data_d = color_q;
                  end
                  if (scan_last) state_d = S_IDLE;
               end else begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_CLEAR;
         cnt_q          <= '0;
         x_q            <= '0;
         y_q            <= '0;
         color_q        <= '0;
         stroke_valid_q <= 1'b0;
         wr_ena_q       <= 1'b0;
         addr_q         <= '0;
         data_q         <= '0;
         clearing_q     <= 1'b1;
         busy_q         <= 1'b1;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         x_q            <= x_d;
         y_q            <= y_d;
         color_q        <= color_d;
         stroke_valid_q <= stroke_valid_d;
         wr_ena_q       <= wr_ena_d;
         addr_q         <= addr_d;
         data_q         <= data_d;
         clearing_q     <= clearing_d;
         busy_q         <= busy_d;
      end
   end

   assign vram_wr_ena  = wr_ena_q;
   assign vram_wr_addr = addr_q;
   assign vram_wr_data = data_q;
   assign clearing     = clearing_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_vram_touch_painter.sv
// Self-checking bench: small display, write log compared against a behavioural model.
module tb_vram_touch_painter;

   localparam int W  = 8;
   localparam int H  = 4;
   localparam int BR = 3;
   localparam int L  = W * H;
   localparam int AW = $clog2(L);
   localparam int RAD = (BR - 1) / 2;

   logic          clk = 1'b0;
   logic          rst, ena, clear_req, touch_valid;
   logic [8:0]    touch_x, touch_y;
   logic [15:0]   color;
   logic          vram_wr_ena;
   logic [AW-1:0] vram_wr_addr;
   logic [15:0]   vram_wr_data;
   logic          clearing, busy;

   vram_touch_painter #(
      .DISPLAY_WIDTH  (W),
      .DISPLAY_HEIGHT (H),
      .BRUSH          (BR),
      .CLEAR_COLOR    (16'hFFFF)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ena          (ena),
      .clear_req    (clear_req),
      .touch_valid  (touch_valid),
      .touch_x      (touch_x),
      .touch_y      (touch_y),
      .color        (color),
      .vram_wr_ena  (vram_wr_ena),
      .vram_wr_addr (vram_wr_addr),
      .vram_wr_data (vram_wr_data),
      .clearing     (clearing),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int wr_q[$];
   int exp_q[$];
   int busy_cnt = 0;
   int clip_cnt = 0;

   // model's record of the last painted stroke
   bit last_v = 1'b0;
   int last_x, last_y, last_c;

   // write log, sampled mid-cycle
   always @(negedge clk) begin
      if (vram_wr_ena === 1'b1) wr_q.push_back((int'(vram_wr_addr) << 16) | int'(vram_wr_data));
      if (busy === 1'b1) busy_cnt++;
      if (busy === 1'b1 && vram_wr_ena !== 1'b1) clip_cnt++;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   function automatic int first_diff(input int a[$], input int b[$]);
      int n = (a.size() < b.size()) ? a.size() : b.size();
      for (int i = 0; i < n; i++) if (a[i] != b[i]) return i;
      if (a.size() != b.size()) return n;
      return -1;
   endfunction

   function automatic string ent(input int q[$], input int i);
      if (i >= q.size()) return "none";
      return $sformatf("%0d:%h", q[i] >>> 16, q[i] & 'hFFFF);
   endfunction

   // Reference model: full clear sweep
   task automatic model_clear();
      for (int a = 0; a < L; a++) exp_q.push_back((a << 16) | 'hFFFF);
      last_v = 1'b0;
   endtask

   // Reference model: one touch sampled in idle
   task automatic model_touch(input int x, input int y, input int c);
      if (x >= W || y >= H) return;
      if (last_v && x == last_x && y == last_y && c == last_c) return;
      last_v = 1'b1;
      last_x = x;
      last_y = y;
      last_c = c;
      for (int dy = -RAD; dy <= RAD; dy++)
         for (int dx = -RAD; dx <= RAD; dx++)
            if (x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
               exp_q.push_back((((y + dy) * W + x + dx) << 16) | c);
   endtask

   task automatic touch_once(input int x, input int y, input int c);
      touch_valid = 1'b1;
      touch_x     = 9'(x);
      touch_y     = 9'(y);
      color       = 16'(c);
      step();
      touch_valid = 1'b0;
   endtask

   task automatic clear_logs();
      wr_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      int d;
      rst = 1'b1; ena = 1'b1; clear_req = 1'b0; touch_valid = 1'b0;
      touch_x = '0; touch_y = '0; color = '0;
      steps(3);
      total++;
      if (vram_wr_ena !== 1'b0 || vram_wr_addr !== '0 || vram_wr_data !== '0) begin
         bad++;
         $display("FAIL reset_write_port: got ena=%b addr=%0d data=%h, want 0/0/0000",
                  vram_wr_ena, vram_wr_addr, vram_wr_data);
      end
      total++;
      if (clearing !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL reset_flags: got clearing=%b busy=%b, want 1/1", clearing, busy);
      end
      clear_logs();
      model_clear();
      rst = 1'b0;
      steps(L);
      total++;
      if (vram_wr_ena !== 1'b1 || vram_wr_addr !== AW'(L - 1) || clearing !== 1'b1) begin
         bad++;
         $display("FAIL clear_last_addr: got ena=%b addr=%0d clearing=%b, want 1/%0d/1",
                  vram_wr_ena, vram_wr_addr, clearing, L - 1);
      end
      step();
      total++;
      if (vram_wr_ena !== 1'b0 || clearing !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL clear_end_flags: got ena=%b clearing=%b busy=%b, want 0/0/0",
                  vram_wr_ena, clearing, busy);
      end
      steps(10);
      d = first_diff(wr_q, exp_q);
      total++;
      if (d >= 0) begin
         bad++;
         $display("FAIL clear_sweep: got %0d writes, want %0d; at %0d got %s want %s",
                  wr_q.size(), exp_q.size(), d, ent(wr_q, d), ent(exp_q, d));
      end
   endtask

   task automatic test_paint_center();
      int d;
      clear_logs();
      model_touch(3, 2, 'h001F);
      touch_once(3, 2, 'h001F);
      busy_cnt = 0;
      steps(12);
      d = first_diff(wr_q, exp_q);
      total++;
      if (d >= 0) begin
         bad++;
         $display("FAIL paint_center: got %0d writes, want %0d; at %0d got %s want %s",
                  wr_q.size(), exp_q.size(), d, ent(wr_q, d), ent(exp_q, d));
      end
      total++;
      if (busy_cnt != BR * BR) begin
         bad++;
         $display("FAIL paint_center_busy: got %0d busy cycles, want %0d", busy_cnt, BR * BR);
      end
   endtask

   task automatic test_hold();
      int d;
      clear_logs();
      touch_valid = 1'b1;
      touch_x = 9'd3; touch_y = 9'd2; color = 16'h001F;
      steps(50);
      total++;
      if (wr_q.size() != 0) begin
         bad++;
         $display("FAIL hold_no_writes: got %0d writes, want 0", wr_q.size());
      end
      model_touch(3, 2, 'h07E0);
      color = 16'h07E0;
      steps(14);
      touch_valid = 1'b0;
      steps(2);
      d = first_diff(wr_q, exp_q);
      total++;
      if (d >= 0) begin
         bad++;
         $display("FAIL hold_recolor: got %0d writes, want %0d; at %0d got %s want %s",
                  wr_q.size(), exp_q.size(), d, ent(wr_q, d), ent(exp_q, d));
      end
   endtask

   task automatic test_paint_corner();
      int d;
      clear_logs();
      model_touch(0, 0, 'hF800);
      touch_once(0, 0, 'hF800);
      busy_cnt = 0;
      clip_cnt = 0;
      steps(12);
      d = first_diff(wr_q, exp_q);
      total++;
      if (d >= 0) begin
         bad++;
         $display("FAIL paint_corner: got %0d writes, want %0d; at %0d got %s want %s",
                  wr_q.size(), exp_q.size(), d, ent(wr_q, d), ent(exp_q, d));
      end
      total++;
      if (busy_cnt != BR * BR || clip_cnt != 5) begin
         bad++;
         $display("FAIL corner_busy_clip: got busy=%0d clipped=%0d, want %0d/5",
                  busy_cnt, clip_cnt, BR * BR);
      end
   endtask

   task automatic test_clear_abort();
      int d;
      clear_logs();
      model_touch(3, 2, 'h001F);
      while (exp_q.size() > 3) void'(exp_q.pop_back());
      model_clear();
      touch_once(3, 2, 'h001F);
      steps(3);
      clear_req = 1'b1;
      touch_valid = 1'b1; touch_x = 9'd5; touch_y = 9'd1; color = 16'h07E0;
      step();
      clear_req = 1'b0;
      touch_valid = 1'b0;
      steps(L + 5);
      d = first_diff(wr_q, exp_q);
      total++;
      if (d >= 0) begin
         bad++;
         $display("FAIL clear_abort: got %0d writes, want %0d; at %0d got %s want %s",
                  wr_q.size(), exp_q.size(), d, ent(wr_q, d), ent(exp_q, d));
      end
      // clear request with a simultaneous touch while idle
      clear_logs();
      model_clear();
      clear_req = 1'b1;
      touch_valid = 1'b1; touch_x = 9'd6; touch_y = 9'd1; color = 16'h07E0;
      step();
      clear_req = 1'b0;
      touch_valid = 1'b0;
      steps(L + 5);
      d = first_diff(wr_q, exp_q);
      total++;
      if (d >= 0) begin
         bad++;
         $display("FAIL clear_with_touch: got %0d writes, want %0d; at %0d got %s want %s",
                  wr_q.size(), exp_q.size(), d, ent(wr_q, d), ent(exp_q, d));
      end
      // the cleared stroke record no longer suppresses the same touch
      clear_logs();
      model_touch(3, 2, 'h001F);
      touch_once(3, 2, 'h001F);
      steps(12);
      d = first_diff(wr_q, exp_q);
      total++;
      if (d >= 0) begin
         bad++;
         $display("FAIL stroke_invalidated: got %0d writes, want %0d; at %0d got %s want %s",
                  wr_q.size(), exp_q.size(), d, ent(wr_q, d), ent(exp_q, d));
      end
   endtask

   task automatic test_out_of_range();
      clear_logs();
      busy_cnt = 0;
      model_touch(8, 1, 'h001F);
      touch_once(8, 1, 'h001F);
      steps(12);
      model_touch(2, 4, 'hF800);
      touch_once(2, 4, 'hF800);
      steps(12);
      total++;
      if (wr_q.size() != exp_q.size() || busy_cnt != 0) begin
         bad++;
         $display("FAIL out_of_range: got %0d writes busy=%0d, want %0d writes busy=0",
                  wr_q.size(), busy_cnt, exp_q.size());
      end
   endtask

   task automatic test_ena_pause();
      int d, n0;
      clear_logs();
      model_clear();
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      steps(10);
      ena = 1'b0;
      step();
      n0 = wr_q.size();
      steps(4);
      total++;
      if (wr_q.size() != n0 || vram_wr_ena !== 1'b0 || clearing !== 1'b1) begin
         bad++;
         $display("FAIL pause_hold: got %0d new writes ena=%b clearing=%b, want 0/0/1",
                  wr_q.size() - n0, vram_wr_ena, clearing);
      end
      ena = 1'b1;
      steps(L + 5);
      d = first_diff(wr_q, exp_q);
      total++;
      if (d >= 0) begin
         bad++;
         $display("FAIL pause_resume: got %0d writes, want %0d; at %0d got %s want %s",
                  wr_q.size(), exp_q.size(), d, ent(wr_q, d), ent(exp_q, d));
      end
   endtask

   task automatic test_random();
      int d, x, y, c, n, guard;
      for (int it = 0; it < 40; it++) begin
         x = int'($urandom_range(0, W + 1));
         y = int'($urandom_range(0, H + 1));
         case ($urandom_range(0, 3))
            0: c = 'h001F;
            1: c = 'hF800;
            2: c = 'h07E0;
            default: c = int'($urandom & 'hFFFF);
         endcase
         if (last_v && $urandom_range(0, 3) == 0) begin
            x = last_x; y = last_y; c = last_c;
         end
         clear_logs();
         model_touch(x, y, c);
         ena = 1'b1;
         touch_once(x, y, c);
         n = 0;
         guard = 0;
         while (n < BR * BR + 2 && guard < 200) begin
            ena = ($urandom_range(0, 3) != 0);
            step();
            if (ena) n++;
            guard++;
         end
         ena = 1'b1;
         steps(2);
         d = first_diff(wr_q, exp_q);
         total++;
         if (d >= 0) begin
            bad++;
            $display("FAIL rand[%0d] (%0d,%0d,%h): got %0d writes, want %0d; at %0d got %s want %s",
                     it, x, y, c, wr_q.size(), exp_q.size(), d, ent(wr_q, d), ent(exp_q, d));
         end
      end
   endtask

   initial begin
      test_reset();
      test_paint_center();
      test_hold();
      test_paint_corner();
      test_clear_abort();
      test_out_of_range();
      test_ena_pause();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
